d_ff: RTL and testbench

- Reference register block: one data input captured by three parallel flip-flop banks that differ only in reset style.
- The three styles are no reset, synchronous reset and asynchronous reset.
- Serves as a library primitive and a reset-style comparison vehicle; all three outputs are registered copies of d_i.
- Sits standalone or as a leaf under any clocked datapath.

---
 rtl/d_ff_pkg.sv | 8 +
 rtl/d_ff_bit.sv | 28 ++
 rtl/d_ff.sv | 34 +++
 tb/tb_d_ff.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared defaults for the d_ff reset-style register block
// Contents:
//   DEFAULT_WIDTH     - default data width of d_ff
//   DEFAULT_RESET_BIT - per-bit value replicated to form the default RESET_VALUE
package d_ff_pkg;
    localparam int unsigned DEFAULT_WIDTH     = 1;
    localparam logic        DEFAULT_RESET_BIT = 1'b0;
endpackage

// File: rtl/d_ff_bit.sv
// d_ff_bit: one data bit captured by three flops that differ only in reset style
// Ports:
//   clk        - rising-edge clock
//   reset      - active-low reset, asynchronous to clk
//   d          - data bit
//   q_norst    - d registered, never reset
//   q_syncrst  - d registered, forced to RESET_BIT at an edge that samples reset low
//   q_asyncrst - d registered, forced to RESET_BIT as soon as reset goes low
module d_ff_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q_norst,
    output logic q_syncrst,
    output logic q_asyncrst
);
    always_ff @(posedge clk)
        q_norst <= d;

    always_ff @(posedge clk)
        q_syncrst <= reset ? d : RESET_BIT;

    always_ff @(posedge clk or negedge reset)
        if (!reset) q_asyncrst <= RESET_BIT;
        else        q_asyncrst <= d;
endmodule

// File: rtl/d_ff.sv
// d_ff: WIDTH-bit register bank with no-reset, sync-reset and async-reset copies of d_i
// Ports:
//   clk          - rising-edge clock, the only clock
//   reset        - active-low reset, asynchronous to clk
//   d_i          - data to register
//   q_norst_o    - d_i registered with no reset
//   q_syncrst_o  - d_i registered with synchronous reset to RESET_VALUE
//   q_asyncrst_o - d_i registered with asynchronous reset to RESET_VALUE
module d_ff
    import d_ff_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_norst_o,
    output logic [WIDTH-1:0] q_syncrst_o,
    output logic [WIDTH-1:0] q_asyncrst_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .d          (d_i[i]),
            .q_norst    (q_norst_o[i]),
            .q_syncrst  (q_syncrst_o[i]),
            .q_asyncrst (q_asyncrst_o[i])
        );
    end
endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: self-checking bench for d_ff at WIDTH=1 and WIDTH=8 (RESET_VALUE=8'hA5)
module tb_d_ff;
    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d1 = 1'b0;
    logic [7:0] d8 = 8'h3C;
    logic       n1, s1, a1;
    logic [7:0] n8, s8, a8;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    d_ff u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .d_i          (d1),
        .q_norst_o    (n1),
        .q_syncrst_o  (s1),
        .q_asyncrst_o (a1)
    );

    d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .d_i          (d8),
        .q_norst_o    (n8),
        .q_syncrst_o  (s8),
        .q_asyncrst_o (a8)
    );

    // Reference: each output is "last value seen at an edge", where the reset-style
    // outputs see RESET_VALUE instead of data when reset was low at the edge, and the
    // async output additionally jumps to RESET_VALUE the moment reset falls.
    logic       m_n1, m_s1, m_a1;
    logic [7:0] m_n8, m_s8, m_a8;

    always @(posedge clk) begin
        m_n1 <= d1;
        m_n8 <= d8;
        m_s1 <= reset ? d1 : 1'b0;
        m_s8 <= reset ? d8 : RV8;
        if (reset) begin
            m_a1 <= d1;
            m_a8 <= d8;
        end
    end

    always @(negedge reset) begin
        m_a1 <= 1'b0;
        m_a8 <= RV8;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d1 = 1'b0;
        d8 = 8'h3C;
        #2 reset = 1'b0;
        #1;
        checks += 2;
        if (a1 !== 1'b0) begin errors++; $display("FAIL reset_async_pre_edge w1 got %h exp %h", a1, 1'b0); end
        if (a8 !== RV8)  begin errors++; $display("FAIL reset_async_pre_edge w8 got %h exp %h", a8, RV8); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 6;
            if (n1 !== 1'b0)  begin errors++; $display("FAIL reset_norst w1 edge%0d got %h exp %h", i, n1, 1'b0); end
            if (s1 !== 1'b0)  begin errors++; $display("FAIL reset_sync w1 edge%0d got %h exp %h", i, s1, 1'b0); end
            if (a1 !== 1'b0)  begin errors++; $display("FAIL reset_async w1 edge%0d got %h exp %h", i, a1, 1'b0); end
            if (n8 !== 8'h3C) begin errors++; $display("FAIL reset_norst w8 edge%0d got %h exp %h", i, n8, 8'h3C); end
            if (s8 !== RV8)   begin errors++; $display("FAIL reset_sync w8 edge%0d got %h exp %h", i, s8, RV8); end
            if (a8 !== RV8)   begin errors++; $display("FAIL reset_async w8 edge%0d got %h exp %h", i, a8, RV8); end
        end
    endtask

    task automatic test_release();
        logic exp;
        reset = 1'b1;
        d1 = 1'b1;
        #2;
        checks += 2;
        if (s1 !== 1'b0) begin errors++; $display("FAIL release_sync_before_edge got %h exp %h", s1, 1'b0); end
        if (a8 !== RV8)  begin errors++; $display("FAIL release_async8_before_edge got %h exp %h", a8, RV8); end
        #1;
        for (int i = 0; i < 2; i++) begin
            exp = (i == 0);
            tick();
            checks += 5;
            if (n1 !== exp)   begin errors++; $display("FAIL release_norst cyc%0d got %h exp %h", i, n1, exp); end
            if (s1 !== exp)   begin errors++; $display("FAIL release_sync cyc%0d got %h exp %h", i, s1, exp); end
            if (a1 !== exp)   begin errors++; $display("FAIL release_async cyc%0d got %h exp %h", i, a1, exp); end
            if (s8 !== 8'h3C) begin errors++; $display("FAIL release_sync w8 cyc%0d got %h exp %h", i, s8, 8'h3C); end
            if (a8 !== 8'h3C) begin errors++; $display("FAIL release_async w8 cyc%0d got %h exp %h", i, a8, 8'h3C); end
            d1 = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        d1 = 1'b1;
        tick();
        #3 reset = 1'b0;
        #1;
        checks += 5;
        if (a1 !== 1'b0)  begin errors++; $display("FAIL mid_async_immediate got %h exp %h", a1, 1'b0); end
        if (s1 !== 1'b1)  begin errors++; $display("FAIL mid_sync_holds got %h exp %h", s1, 1'b1); end
        if (n1 !== 1'b1)  begin errors++; $display("FAIL mid_norst_holds got %h exp %h", n1, 1'b1); end
        if (a8 !== RV8)   begin errors++; $display("FAIL mid_async8_immediate got %h exp %h", a8, RV8); end
        if (s8 !== 8'h3C) begin errors++; $display("FAIL mid_sync8_holds got %h exp %h", s8, 8'h3C); end
        tick();
        checks += 4;
        if (s1 !== 1'b0) begin errors++; $display("FAIL mid_sync_next_edge got %h exp %h", s1, 1'b0); end
        if (a1 !== 1'b0) begin errors++; $display("FAIL mid_async_held got %h exp %h", a1, 1'b0); end
        if (n1 !== 1'b1) begin errors++; $display("FAIL mid_norst_tracks got %h exp %h", n1, 1'b1); end
        if (s8 !== RV8)  begin errors++; $display("FAIL mid_sync8_next_edge got %h exp %h", s8, RV8); end
    endtask

    task automatic test_hold_reset();
        logic [2:0] pat;
        pat = 3'b010;
        for (int i = 0; i < 3; i++) begin
            d1 = pat[i];
            tick();
            checks += 3;
            if (n1 !== pat[i]) begin errors++; $display("FAIL hold_norst cyc%0d got %h exp %h", i, n1, pat[i]); end
            if (s1 !== 1'b0)   begin errors++; $display("FAIL hold_sync cyc%0d got %h exp %h", i, s1, 1'b0); end
            if (a1 !== 1'b0)   begin errors++; $display("FAIL hold_async cyc%0d got %h exp %h", i, a1, 1'b0); end
        end
    endtask

    task automatic test_idle();
        d1 = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks += 3;
            if (n1 !== 1'b1) begin errors++; $display("FAIL idle_norst cyc%0d got %h exp %h", i, n1, 1'b1); end
            if (s1 !== 1'b1) begin errors++; $display("FAIL idle_sync cyc%0d got %h exp %h", i, s1, 1'b1); end
            if (a1 !== 1'b1) begin errors++; $display("FAIL idle_async cyc%0d got %h exp %h", i, a1, 1'b1); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            reset = ($urandom_range(0, 7) != 0);
            #2;
            if ($urandom_range(0, 5) == 0) reset = ~reset;
            tick();
            checks += 6;
            if (n1 !== m_n1) begin errors++; $display("FAIL rand_norst w1 it%0d got %h exp %h", i, n1, m_n1); end
            if (s1 !== m_s1) begin errors++; $display("FAIL rand_sync w1 it%0d got %h exp %h", i, s1, m_s1); end
            if (a1 !== m_a1) begin errors++; $display("FAIL rand_async w1 it%0d got %h exp %h", i, a1, m_a1); end
            if (n8 !== m_n8) begin errors++; $display("FAIL rand_norst w8 it%0d got %h exp %h", i, n8, m_n8); end
            if (s8 !== m_s8) begin errors++; $display("FAIL rand_sync w8 it%0d got %h exp %h", i, s8, m_s8); end
            if (a8 !== m_a8) begin errors++; $display("FAIL rand_async w8 it%0d got %h exp %h", i, a8, m_a8); end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_mid_reset();
        test_hold_reset();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
